time_unit_sequencer: RTL and testbench
======================================

// Module: time_unit_sequencer
// PURPOSE
//   Master side of the big-clock/sleep protocol: generates posedge_big_clk for all sleep units.
//   A time unit advances only when every active controller reports sleeping (output_flag=1).
//   Then one single-clk posedge_big_clk pulse is issued and the global time_unit count advances.
//   Sits at top level between the per-controller sleep units and the run/step debug controls.
// PARAMETERS
//   NUM_CTRL    4     number of controllers, i.e. sleep units observed
//   MIN_PERIOD  4     min clk cycles in SETTLE before a tick; >=2 so sleep flags are re-sampled after the pulse
//   TIME_W      11    width of time_unit; matches sleep_val width
//   TIMEOUT     1024  SETTLE cycles without all_asleep before hang is raised
// PORTS
//   clk              in   1         system clock
//   rst_n            in   1         synchronous active-low reset
//   sleeping         in   NUM_CTRL  output_flag of each sleep unit
//   active           in   NUM_CTRL  1 = controller present; 0 = its sleeping bit is ignored
//   run              in   1         level: free-run time units
//   step             in   1         1-cycle pulse: advance exactly one time unit while not running
//   posedge_big_clk  out  1         1-cycle tick to all sleep units
//   time_unit        out  TIME_W    count of issued ticks, wraps
//   all_asleep       out  1         comb: &(sleeping | ~active)
//   running          out  1         state != IDLE
//   hang             out  1         sticky: TIMEOUT reached in SETTLE
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, cnt=0, step_pend=0.
//     Outputs: posedge_big_clk=0, time_unit=0, hang=0.
//     Reset wins over every other input in any state, including mid-SETTLE and in TICK.
//   States: IDLE, SETTLE, TICK. posedge_big_clk is 1 only while state==TICK; it is registered.
//   IDLE:
//     run=1 -> SETTLE, cnt=0.
//     step=1 (run=0) -> SETTLE, cnt=0, step_pend=1.
//     Otherwise stay; no pulses.
//   SETTLE:
//     cnt increments each cycle, saturating at TIMEOUT.
//     -> TICK when cnt>=MIN_PERIOD-1 and all_asleep.
//     Result: with all asleep, one tick every MIN_PERIOD+1 clks.
//     -> IDLE when run=0 and step_pend=0: cnt cleared, time_unit held, no pulse.
//   TICK (exactly one cycle):
//     time_unit <= time_unit+1, wrapping from 2^TIME_W-1 to 0.
//     -> IDLE if step_pend (clear step_pend) or run=0.
//     -> else SETTLE with cnt=0.
//   all_asleep:
//     If active==0, all_asleep=1, so ticks free-run at MIN_PERIOD+1.
//     Changes on sleeping/active take effect on the next SETTLE evaluation.
//   hang:
//     Set when cnt reaches TIMEOUT in SETTLE.
//     Cleared by reset, or on run falling 1->0 while step_pend=0.
//     Does not block ticking: if all_asleep later rises, TICK proceeds.
//   Simultaneous events:
//     step while running or in SETTLE/TICK is ignored.
//     run dropping in TICK: the pulse still completes, then IDLE.
//     Inputs never cause two consecutive pulse cycles.
// STRUCTURE
//   Shared header shenzhen_defs.vh holds:
//     state encodings SEQ_IDLE=2'd0, SEQ_SETTLE=2'd1, SEQ_TICK=2'd2;
//     SLEEP_W=11, the common sleep_val/time_unit width.
//   One sub-module, settle_counter:
//     clear/enable inputs;
//     outputs min_reached (cnt>=MIN_PERIOD-1) and timeout (cnt==TIMEOUT);
//     width $clog2(TIMEOUT+1).
//   FSM, time_unit register and hang flag stay in the top module.
// TESTING (NUM_CTRL=4, MIN_PERIOD=4, TIMEOUT=16 unless noted)
//   1 reset, run=0, sleeping=4'hF for 50 clks -> no posedge_big_clk, time_unit=0, running=0.
//   2 run=1, active=4'hF, sleeping=4'hF -> pulse every 5 clks; exactly 3 pulses in 15 clks; time_unit=3.
//   3 sleeping=4'h7 for 10 clks -> no pulse; then set bit3 -> pulse on the next clk edge.
//     Also sleeping=0 for 16 SETTLE clks -> hang=1, held until run falls.
//   4 active=4'h5, sleeping=4'h5 -> ticks every 5 clks, inactive bits ignored.
//     Also active=0, sleeping=0 -> ticks every 5 clks.
//   5 run=0, step pulse -> exactly one pulse after 5 clks, time_unit+1, back in IDLE.
//     step during run -> no extra pulse.
//   6 TIME_W=3, run for 8 ticks -> time_unit wraps 7->0.
//     rst_n=0 mid-SETTLE -> next cycle IDLE, time_unit=0, hang=0, no pulse.

Source files
------------

// File: rtl/time_unit_sequencer_pkg.sv
// Shared definitions for the big-clock sequencer: state encodings and the
// common sleep_val / time_unit width.
package time_unit_sequencer_pkg;

    localparam int SLEEP_W = 11;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_SETTLE = 2'd1,
        SEQ_TICK   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/time_unit_sequencer_settle_counter.sv
// Counts SETTLE cycles, saturating at TIMEOUT; flags the minimum settle
// period and the hang threshold.
module settle_counter #(
    parameter int MIN_PERIOD = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic min_reached,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD - 1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating settle-cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign min_reached = (cnt_r >= CNT_MIN);
    assign timeout     = (cnt_r == CNT_MAX);

endmodule

// File: rtl/time_unit_sequencer.sv
// Master of the big-clock/sleep protocol: issues one posedge_big_clk pulse per
// time unit once every active controller reports sleeping.
import time_unit_sequencer_pkg::*;

module time_unit_sequencer #(
    parameter int NUM_CTRL   = 4,
    parameter int MIN_PERIOD = 4,
    parameter int TIME_W     = SLEEP_W,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CTRL-1:0] sleeping,
    input  logic [NUM_CTRL-1:0] active,
    input  logic                run,
    input  logic                step,
    output logic                posedge_big_clk,
    output logic [TIME_W-1:0]   time_unit,
    output logic                all_asleep,
    output logic                running,
    output logic                hang
);

    seq_state_e        state_r, state_nxt_s;
    logic              step_pend_r, step_pend_nxt_s;
    logic              run_d_r;
    logic              hang_r, hang_nxt_s;
    logic              pulse_r;
    logic              running_r;
    logic [TIME_W-1:0] time_unit_r;
    logic              min_reached_s;
    logic              timeout_s;
    logic              all_asleep_s;

    // Inactive controllers count as asleep
    assign all_asleep_s = &(sleeping | ~active);

    settle_counter #(
        .MIN_PERIOD (MIN_PERIOD),
        .TIMEOUT    (TIMEOUT)
    ) u_settle_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state_r != SEQ_SETTLE),
        .enable      (state_r == SEQ_SETTLE),
        .min_reached (min_reached_s),
        .timeout     (timeout_s)
    );

    // Next-state logic; a pending step keeps SETTLE alive with run low
    always_comb begin
        state_nxt_s     = state_r;
        step_pend_nxt_s = step_pend_r;
        case (state_r)
            SEQ_IDLE: begin
                if (run) begin
                    state_nxt_s = SEQ_SETTLE;
                end else if (step) begin
                    state_nxt_s     = SEQ_SETTLE;
                    step_pend_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = SEQ_IDLE;
                end
            end
            SEQ_SETTLE: begin
                if (!run && !step_pend_r) begin
                    state_nxt_s = SEQ_IDLE;
                end else if (min_reached_s && all_asleep_s) begin
                    state_nxt_s = SEQ_TICK;
                end else begin
                    state_nxt_s = SEQ_SETTLE;
                end
            end
            SEQ_TICK: begin
                step_pend_nxt_s = 1'b0;
                if (step_pend_r || !run) begin
                    state_nxt_s = SEQ_IDLE;
                end else begin
                    state_nxt_s = SEQ_SETTLE;
                end
            end
            default: begin
                state_nxt_s     = SEQ_IDLE;
                step_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Sticky hang flag; a run stop (not a step) clears it
    always_comb begin
        hang_nxt_s = hang_r;
        if (run_d_r && !run && !step_pend_r) begin
            hang_nxt_s = 1'b0;
        end else if ((state_r == SEQ_SETTLE) && timeout_s) begin
            hang_nxt_s = 1'b1;
        end else begin
            hang_nxt_s = hang_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= SEQ_IDLE;
            step_pend_r <= 1'b0;
            run_d_r     <= 1'b0;
            hang_r      <= 1'b0;
            pulse_r     <= 1'b0;
            running_r   <= 1'b0;
            time_unit_r <= {TIME_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            step_pend_r <= step_pend_nxt_s;
            run_d_r     <= run;
            hang_r      <= hang_nxt_s;
            pulse_r     <= (state_nxt_s == SEQ_TICK);
            running_r   <= (state_nxt_s != SEQ_IDLE);
            if (state_r == SEQ_TICK) begin
                time_unit_r <= time_unit_r + TIME_W'(1);
            end else begin
                time_unit_r <= time_unit_r;
            end
        end
    end

    assign posedge_big_clk = pulse_r;
    assign time_unit       = time_unit_r;
    assign all_asleep      = all_asleep_s;
    assign running         = running_r;
    assign hang            = hang_r;

endmodule

// File: tb/tb_time_unit_sequencer.sv
// Directed bench for time_unit_sequencer; a second 3-bit instance shares all
// inputs so the time_unit wrap can be observed.
module tb_time_unit_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sleeping;
    logic [3:0]  active;
    logic        run;
    logic        step;
    logic        posedge_big_clk;
    logic [10:0] time_unit;
    logic        all_asleep;
    logic        running;
    logic        hang;
    logic        pulse_w3;
    logic [2:0]  time_unit_w3;
    logic        all_asleep_w3;
    logic        running_w3;
    logic        hang_w3;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt  = 0;
    int consec_cnt = 0;
    logic prev_pulse = 1'b0;
    int base;

    time_unit_sequencer #(
        .NUM_CTRL(4), .MIN_PERIOD(4), .TIME_W(11), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sleeping(sleeping), .active(active),
        .run(run), .step(step), .posedge_big_clk(posedge_big_clk),
        .time_unit(time_unit), .all_asleep(all_asleep), .running(running),
        .hang(hang)
    );

    time_unit_sequencer #(
        .NUM_CTRL(4), .MIN_PERIOD(4), .TIME_W(3), .TIMEOUT(16)
    ) dut_w3 (
        .clk(clk), .rst_n(rst_n), .sleeping(sleeping), .active(active),
        .run(run), .step(step), .posedge_big_clk(pulse_w3),
        .time_unit(time_unit_w3), .all_asleep(all_asleep_w3), .running(running_w3),
        .hang(hang_w3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counter and back-to-back pulse detector, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (posedge_big_clk) pulse_cnt++;
        if (posedge_big_clk && prev_pulse) consec_cnt++;
        prev_pulse = posedge_big_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        active = 4'hF; sleeping = 4'hF;
        wait_clk(3);
        check_eq("rst_pulse", 32'(posedge_big_clk), 32'd0);
        check_eq("rst_time", 32'(time_unit), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_hang", 32'(hang), 32'd0);
        rst_n = 1'b1;

        // 1: idle with everyone asleep
        base = pulse_cnt;
        wait_clk(50);
        check_eq("idle_pulses", 32'(pulse_cnt - base), 32'd0);
        check_eq("idle_time", 32'(time_unit), 32'd0);
        check_eq("idle_running", 32'(running), 32'd0);

        // 2: free run, one tick every 5 clks
        run = 1'b1;
        base = pulse_cnt;
        wait_clk(4);
        check_eq("run_no_early", 32'(pulse_cnt - base), 32'd0);
        wait_clk(1);
        check_eq("run_first", 32'(posedge_big_clk), 32'd1);
        wait_clk(10);
        check_eq("run_3pulses", 32'(pulse_cnt - base), 32'd3);
        wait_clk(1);
        check_eq("run_time3", 32'(time_unit), 32'd3);

        // 3: one controller awake blocks the tick
        sleeping = 4'h7;
        base = pulse_cnt;
        wait_clk(10);
        check_eq("awake_block", 32'(pulse_cnt - base), 32'd0);
        check_eq("awake_nohang", 32'(hang), 32'd0);
        sleeping = 4'hF;
        wait_clk(1);
        check_eq("wake_tick", 32'(posedge_big_clk), 32'd1);
        wait_clk(1);
        check_eq("wake_time4", 32'(time_unit), 32'd4);
        sleeping = 4'h0;
        base = pulse_cnt;
        wait_clk(20);
        check_eq("hang_set", 32'(hang), 32'd1);
        check_eq("hang_nopulse", 32'(pulse_cnt - base), 32'd0);
        sleeping = 4'hF;
        wait_clk(1);
        check_eq("hang_tick", 32'(posedge_big_clk), 32'd1);
        check_eq("hang_held", 32'(hang), 32'd1);
        run = 1'b0;
        wait_clk(1);
        check_eq("hang_clear", 32'(hang), 32'd0);
        check_eq("stop_time5", 32'(time_unit), 32'd5);
        check_eq("stop_idle", 32'(running), 32'd0);

        // 4: inactive controllers ignored
        active = 4'h5; sleeping = 4'h5; run = 1'b1;
        base = pulse_cnt;
        wait_clk(1);
        check_eq("mask_asleep", 32'(all_asleep), 32'd1);
        wait_clk(9);
        check_eq("mask_2pulses", 32'(pulse_cnt - base), 32'd2);
        sleeping = 4'hA;
        wait_clk(6);
        check_eq("mask_awake", 32'(all_asleep), 32'd0);
        check_eq("mask_block", 32'(pulse_cnt - base), 32'd2);
        active = 4'h0; sleeping = 4'h0;
        wait_clk(11);
        check_eq("none_asleep", 32'(all_asleep), 32'd1);
        check_eq("none_pulses", 32'(pulse_cnt - base), 32'd5);
        check_eq("none_in_tick", 32'(posedge_big_clk), 32'd1);
        run = 1'b0;
        wait_clk(1);
        check_eq("tick_stop_time", 32'(time_unit), 32'd10);
        check_eq("tick_stop_idle", 32'(running), 32'd0);
        active = 4'hF; sleeping = 4'hF;

        // 5: single step, then step during run
        base = pulse_cnt;
        step = 1'b1;
        wait_clk(1);
        step = 1'b0;
        wait_clk(3);
        check_eq("step_wait", 32'(posedge_big_clk), 32'd0);
        check_eq("step_running", 32'(running), 32'd1);
        wait_clk(1);
        check_eq("step_tick", 32'(posedge_big_clk), 32'd1);
        wait_clk(1);
        check_eq("step_idle", 32'(running), 32'd0);
        check_eq("step_time11", 32'(time_unit), 32'd11);
        wait_clk(10);
        check_eq("step_once", 32'(pulse_cnt - base), 32'd1);
        base = pulse_cnt;
        run = 1'b1;
        wait_clk(2);
        step = 1'b1;
        wait_clk(1);
        step = 1'b0;
        wait_clk(12);
        check_eq("runstep_pulses", 32'(pulse_cnt - base), 32'd3);
        run = 1'b0;
        wait_clk(1);
        check_eq("runstep_time", 32'(time_unit), 32'd14);
        wait_clk(10);
        check_eq("runstep_noextra", 32'(pulse_cnt - base), 32'd3);
        check_eq("w3_time6", 32'(time_unit_w3), 32'd6);

        // 6: 3-bit counter wraps 7 -> 0
        run = 1'b1;
        wait_clk(6);
        check_eq("w3_time7", 32'(time_unit_w3), 32'd7);
        wait_clk(4);
        run = 1'b0;
        wait_clk(1);
        check_eq("w3_wrap", 32'(time_unit_w3), 32'd0);
        check_eq("time16", 32'(time_unit), 32'd16);

        // reset mid-SETTLE
        run = 1'b1;
        wait_clk(2);
        rst_n = 1'b0;
        base = pulse_cnt;
        wait_clk(1);
        check_eq("mrst_pulse", 32'(posedge_big_clk), 32'd0);
        check_eq("mrst_time", 32'(time_unit), 32'd0);
        check_eq("mrst_running", 32'(running), 32'd0);
        check_eq("mrst_hang", 32'(hang), 32'd0);
        wait_clk(6);
        check_eq("mrst_nopulse", 32'(pulse_cnt - base), 32'd0);
        rst_n = 1'b1; run = 1'b0;
        wait_clk(2);
        check_eq("post_rst_time", 32'(time_unit), 32'd0);

        check_eq("no_consec", 32'(consec_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
